uart_cmd_decode: RTL and testbench
==================================

# uart_cmd_decode

Command decoder and scheduler between `uart_rx` and the SDRAM write/read path. It parses the byte stream from `rx_data`/`po_flag` into write commands (header plus fixed-length payload) and read commands (header only). Payload bytes go to the SDRAM write FIFO. The block then issues a one-cycle write or read trigger to the SDRAM top once the SDRAM arbiter reports idle.

## Interface
- `WR_CMD`, 8'h55, header byte that starts a write command
- `RD_CMD`, 8'hAA, header byte that is a read command
- `PAYLOAD_LEN`, 4, payload bytes per write command (1..255)
- `TIMEOUT_CYC`, 2000, maximum idle cycles between payload bytes before abort (≥2)
- `sclk` in 1: system clock
- `s_rst` in 1: reset, synchronous, active-high
- `rx_data` in 8: received byte, valid only when `po_flag` is high
- `po_flag` in 1: one-cycle strobe from `uart_rx` marking a new byte
- `sdram_busy` in 1: SDRAM arbiter busy; triggers are withheld while high
- `wfifo_wr_en` out 1: write-FIFO push strobe
- `wfifo_data` out 8: write-FIFO push data
- `wfifo_clr` out 1: one-cycle pulse that discards a partial payload
- `wr_trig` out 1: one-cycle SDRAM write-burst request
- `rd_trig` out 1: one-cycle SDRAM read-burst request
- `cmd_err` out 1: one-cycle error pulse
- `cmd_busy` out 1: high whenever the state is not IDLE

## Operation
- All outputs are registered. On reset every output is 0, `wfifo_data` is 8'h00, state is IDLE, and `byte_cnt` and `to_cnt` are 0.
- **IDLE**
  - `po_flag` with `rx_data==WR_CMD`: go to PAYLOAD, `byte_cnt`=0, `to_cnt`=0.
  - `po_flag` with `rx_data==RD_CMD`: go to RD_PEND.
  - `po_flag` with any other byte: pulse `cmd_err` and stay in IDLE.
- **PAYLOAD**
  - On each `po_flag`: `wfifo_wr_en`=1 and `wfifo_data`=`rx_data` on the next cycle; `byte_cnt` increments; `to_cnt` clears.
  - Header values received here are treated as payload data and are not decoded.
  - When `po_flag` arrives with `byte_cnt==PAYLOAD_LEN-1`, go to WR_PEND.
  - Without `po_flag`, `to_cnt` increments. When it reaches `TIMEOUT_CYC-1`, pulse `cmd_err` and `wfifo_clr`, then return to IDLE.
  - Widths: `byte_cnt` is 8 bits; `to_cnt` is `$clog2(TIMEOUT_CYC)` bits. Neither counter wraps, because each is cleared on exit.
- **WR_PEND**
  - When `sdram_busy==0`: pulse `wr_trig` and go to IDLE.
  - Otherwise hold indefinitely, with no timeout.
- **RD_PEND**
  - When `sdram_busy==0`: pulse `rd_trig` and go to IDLE.
  - Otherwise hold.
- **`po_flag` in WR_PEND or RD_PEND:** the byte is dropped and `cmd_err` pulses. The state does not change, and the byte is not reinterpreted as a header.
- **`s_rst` mid-command:** the state returns to IDLE and all strobes clear. `wfifo_clr` is not pulsed; the FIFO shares `s_rst` and is reset by it.
- `wr_trig` and `rd_trig` are never high together, and at most one trigger is issued per command.

## Timing
- Let `po_flag` be high at cycle N.
  - `cmd_busy` rises at N+1.
  - A payload byte pushed at N appears on `wfifo_wr_en`/`wfifo_data` at N+1.
- Read command, `sdram_busy` low: state is RD_PEND at N+1 and `rd_trig` is high at N+2. `cmd_busy` falls at N+2.
- Last payload byte at N, `sdram_busy` low:
  - The final `wfifo_wr_en` is at N+1.
  - `wr_trig` is at N+2, so the trigger always follows the last FIFO push by one cycle.
- If `sdram_busy` is high, the trigger is issued on the cycle after the first sampled low.
- Timeout: the last `po_flag` is at cycle M. `cmd_err` and `wfifo_clr` are high at M+`TIMEOUT_CYC`.
- An invalid header at N produces `cmd_err` at N+1.
- Back-to-back commands are accepted. A header may arrive the cycle after a trigger.

## Test plan
- Reset, then stream 55 11 22 33 44 with `sdram_busy`=0. Required: four `wfifo_wr_en` pulses carrying 11, 22, 33, 44 in order; one `wr_trig` exactly 1 cycle after the last push; no `cmd_err`.
- Send AA with `sdram_busy` held high for 100 cycles. Required: `rd_trig` is 0 during the hold and pulses once on the cycle after `sdram_busy` falls; `cmd_busy` is high throughout the wait.
- Send 55 11 22, then silence. Required: `cmd_err` and `wfifo_clr` pulse together `TIMEOUT_CYC` cycles after the 22 byte; no `wr_trig`; `cmd_busy` falls.
- Send 3C, then AA. Required: one `cmd_err` for 3C, then a normal `rd_trig`.
- Send 55 AA 55 AA AA. Required: the payload is pushed as AA 55 AA AA; `wr_trig` follows; no `rd_trig`.
- Assert `s_rst` after 55 11, then send AA. Required: all outputs are 0 during reset, no `wr_trig`, and AA decodes to a single `rd_trig`.

Source files
------------

// File: rtl/uart_cmd_decode.sv
// Byte-stream command decoder: turns uart_rx bytes into write (header + payload)
// and read (header only) commands, feeds the SDRAM write FIFO and issues triggers.
module uart_cmd_decode #(
  parameter logic [7:0] WR_CMD      = 8'h55,
  parameter logic [7:0] RD_CMD      = 8'hAA,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         TIMEOUT_CYC = 2000
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  input  logic       sdram_busy,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wfifo_clr,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       cmd_err,
  output logic       cmd_busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);
  // Abort is decided one cycle early so the registered pulse lands exactly
  // TIMEOUT_CYC cycles after the last payload byte.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WR_PEND,
    RD_PEND
  } state_t;

  state_t          state;
  logic [7:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state       <= IDLE;
      byte_cnt    <= 8'd0;
      to_cnt      <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= 8'h00;
      wfifo_clr   <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_busy    <= 1'b0;
    end else begin
      wfifo_wr_en <= 1'b0;
      wfifo_clr   <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (po_flag) begin
            if (rx_data == WR_CMD) begin
              state    <= PAYLOAD;
              byte_cnt <= 8'd0;
              to_cnt   <= '0;
              cmd_busy <= 1'b1;
            end else if (rx_data == RD_CMD) begin
              state    <= RD_PEND;
              cmd_busy <= 1'b1;
            end else begin
              cmd_err  <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (po_flag) begin
            wfifo_wr_en <= 1'b1;
            wfifo_data  <= rx_data;
            to_cnt      <= '0;
            if (byte_cnt == LAST_IDX) begin
              state    <= WR_PEND;
              byte_cnt <= 8'd0;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            wfifo_clr <= 1'b1;
            cmd_err   <= 1'b1;
            state     <= IDLE;
            cmd_busy  <= 1'b0;
            to_cnt    <= '0;
            byte_cnt  <= 8'd0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WR_PEND: begin
          // Stray bytes while waiting are dropped, never decoded as headers.
          if (po_flag) cmd_err <= 1'b1;
          if (!sdram_busy) begin
            wr_trig  <= 1'b1;
            state    <= IDLE;
            cmd_busy <= 1'b0;
          end
        end
        RD_PEND: begin
          if (po_flag) cmd_err <= 1'b1;
          if (!sdram_busy) begin
            rd_trig  <= 1'b1;
            state    <= IDLE;
            cmd_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cmd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Directed bench for uart_cmd_decode: a per-cycle vector table plus
// hand-written sequences for busy hold, timeout and mid-command reset.
module tb_uart_cmd_decode;

  localparam int TO = 2000;

  logic       sclk = 1'b0;
  logic       s_rst;
  logic [7:0] rx_data;
  logic       po_flag;
  logic       sdram_busy;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_data;
  logic       wfifo_clr;
  logic       wr_trig;
  logic       rd_trig;
  logic       cmd_err;
  logic       cmd_busy;

  logic [13:0] obs;
  assign obs = {wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, cmd_err, cmd_busy};

  uart_cmd_decode #(
    .WR_CMD(8'h55), .RD_CMD(8'hAA), .PAYLOAD_LEN(4), .TIMEOUT_CYC(TO)
  ) dut (
    .sclk(sclk), .s_rst(s_rst), .rx_data(rx_data), .po_flag(po_flag),
    .sdram_busy(sdram_busy), .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data),
    .wfifo_clr(wfifo_clr), .wr_trig(wr_trig), .rd_trig(rd_trig),
    .cmd_err(cmd_err), .cmd_busy(cmd_busy)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        po;
    logic [7:0]  data;
    logic        busy;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [13:0] e(input logic we, input logic [7:0] d, input logic clr,
                                    input logic wt, input logic rt, input logic er,
                                    input logic bz);
    return {we, d, clr, wt, rt, er, bz};
  endfunction

  // Apply inputs for one cycle, then settle just after the edge.
  task automatic step(input logic po, input logic [7:0] d, input logic busy);
    po_flag = po;
    rx_data = d;
    sdram_busy = busy;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    int rd_cnt, bz_low, err_cnt, clr_cnt, wr_cnt;

    // write 55 11 22 33 44, trigger one cycle after last push
    vecs[0]  = '{1'b1, 8'h55, 1'b0, e(0, 8'h00, 0, 0, 0, 0, 1)};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, e(1, 8'h11, 0, 0, 0, 0, 1)};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, e(1, 8'h22, 0, 0, 0, 0, 1)};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, e(1, 8'h33, 0, 0, 0, 0, 1)};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, e(1, 8'h44, 0, 0, 0, 0, 1)};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, e(0, 8'h44, 0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, e(0, 8'h44, 0, 0, 0, 0, 0)};
    // headers inside a payload are plain data
    vecs[7]  = '{1'b1, 8'h55, 1'b0, e(0, 8'h44, 0, 0, 0, 0, 1)};
    vecs[8]  = '{1'b1, 8'hAA, 1'b0, e(1, 8'hAA, 0, 0, 0, 0, 1)};
    vecs[9]  = '{1'b1, 8'h55, 1'b0, e(1, 8'h55, 0, 0, 0, 0, 1)};
    vecs[10] = '{1'b1, 8'hAA, 1'b0, e(1, 8'hAA, 0, 0, 0, 0, 1)};
    vecs[11] = '{1'b1, 8'hAA, 1'b0, e(1, 8'hAA, 0, 0, 0, 0, 1)};
    vecs[12] = '{1'b0, 8'h00, 1'b0, e(0, 8'hAA, 0, 1, 0, 0, 0)};
    // invalid header arriving while wr_trig is visible, then a read
    vecs[13] = '{1'b1, 8'h3C, 1'b0, e(0, 8'hAA, 0, 0, 0, 1, 0)};
    vecs[14] = '{1'b1, 8'hAA, 1'b0, e(0, 8'hAA, 0, 0, 0, 0, 1)};
    vecs[15] = '{1'b0, 8'h00, 1'b0, e(0, 8'hAA, 0, 0, 1, 0, 0)};
    vecs[16] = '{1'b0, 8'h00, 1'b0, e(0, 8'hAA, 0, 0, 0, 0, 0)};

    s_rst = 1'b1;
    po_flag = 1'b0;
    rx_data = 8'h00;
    sdram_busy = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_state", obs, 14'h0);
    s_rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].po, vecs[i].data, vecs[i].busy);
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // read held off by sdram_busy for 100 cycles
    step(1'b1, 8'hAA, 1'b1);
    chk("rd_hold_start", obs, e(0, 8'hAA, 0, 0, 0, 0, 1));
    rd_cnt = 0;
    bz_low = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (rd_trig) rd_cnt++;
      if (!cmd_busy) bz_low++;
    end
    chki("rd_hold_no_trig", rd_cnt, 0);
    chki("rd_hold_busy_low_cycles", bz_low, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("rd_release", obs, e(0, 8'hAA, 0, 0, 1, 0, 0));
    step(1'b0, 8'h00, 1'b0);
    chk("rd_single_pulse", obs, e(0, 8'hAA, 0, 0, 0, 0, 0));

    // partial payload followed by silence
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    chk("to_last_push", obs, e(1, 8'h22, 0, 0, 0, 0, 1));
    err_cnt = 0;
    clr_cnt = 0;
    bz_low = 0;
    wr_cnt = 0;
    for (int k = 1; k <= TO - 2; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (cmd_err) err_cnt++;
      if (wfifo_clr) clr_cnt++;
      if (!cmd_busy) bz_low++;
      if (wr_trig) wr_cnt++;
    end
    chki("to_early_err", err_cnt + clr_cnt, 0);
    chki("to_early_busy_low", bz_low, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("to_abort", obs, e(0, 8'h22, 1, 0, 0, 1, 0));
    step(1'b0, 8'h00, 1'b0);
    if (wr_trig) wr_cnt++;
    chk("to_after", obs, e(0, 8'h22, 0, 0, 0, 0, 0));
    chki("to_no_wr_trig", wr_cnt, 0);

    // reset in the middle of a write command
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk("rst_mid_push", obs, e(1, 8'h11, 0, 0, 0, 0, 1));
    s_rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("rst_mid_cyc0", obs, 14'h0);
    step(1'b0, 8'h00, 1'b0);
    chk("rst_mid_cyc1", obs, 14'h0);
    s_rst = 1'b0;
    step(1'b1, 8'hAA, 1'b0);
    chk("rst_then_rd_hdr", obs, e(0, 8'h00, 0, 0, 0, 0, 1));
    step(1'b0, 8'h00, 1'b0);
    chk("rst_then_rd_trig", obs, e(0, 8'h00, 0, 0, 1, 0, 0));
    step(1'b0, 8'h00, 1'b0);
    chk("rst_then_idle", obs, 14'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
